// File: rtl/conv_pkg.sv
// Purpose : shared widths, FSM encoding and the round/saturate helper for the conv write-back path.
// Latency : n/a (types and a combinational function only).
// Backpr. : n/a.
package conv_pkg;

  localparam int PW   = 32;  // PE product width, signed
  localparam int ACCW = 40;  // window accumulator width, signed
  localparam int OUTW = 16;  // output pixel width, signed

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  // Returns {sat, pix}. Rounds half toward +inf by adding 2^(shift-1) before
  // the arithmetic shift. The add is done one bit wider than the accumulator
  // so the bias can never wrap a sum that sits at the accumulator's limit.
  function automatic logic [OUTW:0] round_sat(input logic signed [ACCW-1:0] sum,
                                              input int                     shift);
    logic signed [ACCW:0]   wide;
    logic signed [ACCW:0]   half;
    logic signed [ACCW:0]   r;
    logic signed [ACCW:0]   pmax;
    logic signed [ACCW:0]   nmin;
    logic                   sat;
    logic [OUTW-1:0]        pix;
    wide = {sum[ACCW-1], sum};
    half = (ACCW+1)'(1) <<< (shift - 1);
    r    = (wide + half) >>> shift;
    pmax = (ACCW+1)'((1 <<< (OUTW - 1)) - 1);
    nmin = -pmax - (ACCW+1)'(1);
    if (r > pmax) begin
      sat = 1'b1;
      pix = pmax[OUTW-1:0];
    end else if (r < nmin) begin
      sat = 1'b1;
      pix = nmin[OUTW-1:0];
    end else begin
      sat = 1'b0;
      pix = r[OUTW-1:0];
    end
    return {sat, pix};
  endfunction

endpackage

// File: rtl/conv_window_acc_if.sv
// Purpose : product-in / pixel-out bundle between PE array, window accumulator and write-back.
// Latency : n/a (wires only).
// Backpr. : pix_valid/pix_ready handshake on the pixel side; stall is an advisory hint upstream.
// Ports   : master = PE controller / write-back side (drives products and pix_ready),
//           slave  = conv_window_acc (drives pixels, stall and status).
interface conv_window_acc_if;
  import conv_pkg::*;

  logic                   prod_valid;
  logic signed [PW-1:0]   prod_in;
  logic                   frame_start;
  logic                   stall;
  logic                   pix_valid;
  logic                   pix_ready;
  logic signed [OUTW-1:0] pix_data;
  logic                   pix_sat;
  logic [7:0]             tap_cnt;
  logic                   drop_err;

  modport master (
    output prod_valid, prod_in, frame_start, pix_ready,
    input  stall, pix_valid, pix_data, pix_sat, tap_cnt, drop_err
  );

  modport slave (
    input  prod_valid, prod_in, frame_start, pix_ready,
    output stall, pix_valid, pix_data, pix_sat, tap_cnt, drop_err
  );

endinterface

// File: rtl/conv_out_fifo.sv
// Purpose : DEPTH x WIDTH first-word-fall-through FIFO with occupancy count.
// Latency : 1 cycle push-to-head; head is visible combinationally once count != 0.
// Backpr. : push while full without a same-cycle pop is ignored; caller owns drop handling.
// Ports   : clk/reset, push/push_dat, pop, count (0..DEPTH), head_dat (valid when count != 0).
module conv_out_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head_dat
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

  // Storage needs no reset: nothing reads it while count == 0.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_dat = mem[rd_ptr];

endmodule

// File: rtl/conv_window_acc.sv
// Purpose : sums KTAPS signed PE products per window, rounds/saturates to a pixel, queues it.
// Latency : pixel at the FIFO head 1 cycle after the last tap is accepted.
// Backpr. : products are never refused; stall hints the FIFO is nearly full, overflow drops and sets drop_err.
// Ports   : clk, reset (async active-low), bus (slave): prod_valid/prod_in/frame_start in,
//           pix_valid/pix_data/pix_sat out with pix_ready in, stall/tap_cnt/drop_err status out.
module conv_window_acc
  import conv_pkg::*;
#(
  parameter int KTAPS      = 9,
  parameter int SHIFT      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  conv_window_acc_if.slave  bus
);

  localparam int         CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [7:0] LAST_TAP = 8'(KTAPS - 1);

  state_t                 state_q, state_d;
  logic [7:0]             tap_q, tap_d;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic signed [ACCW-1:0] prod_x;
  logic signed [ACCW-1:0] sum;
  logic                   last_tap;
  logic                   push;
  logic                   pop;
  logic                   full;
  logic                   pix_valid;
  logic [OUTW:0]          push_dat;
  logic [OUTW:0]          head;
  logic [CW-1:0]          count;
  logic                   stall_q;
  logic                   drop_err_q;

  assign prod_x   = {{(ACCW-PW){bus.prod_in[PW-1]}}, bus.prod_in};
  assign sum      = acc_q + prod_x;
  assign last_tap = bus.prod_valid && (tap_q == LAST_TAP);
  // frame_start wins over completion: a window cut short never reaches the FIFO.
  assign push     = last_tap && !bus.frame_start;
  assign push_dat = round_sat(sum, SHIFT);
  assign full     = (count == CW'(FIFO_DEPTH));
  assign pop      = pix_valid && bus.pix_ready;

  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    acc_d   = acc_q;
    if (bus.frame_start) begin
      state_d = IDLE;
      tap_d   = 8'd0;
      // A product arriving with frame_start opens the new window as tap 0.
      if (bus.prod_valid) begin
        acc_d   = prod_x;
        tap_d   = 8'd1;
        state_d = ACCUM;
      end
    end else if (bus.prod_valid) begin
      case (state_q)
        IDLE:    acc_d = prod_x;
        ACCUM:   acc_d = sum;
        default: acc_d = acc_q;
      endcase
      if (last_tap) begin
        tap_d   = 8'd0;
        state_d = IDLE;
      end else begin
        tap_d   = tap_q + 8'd1;
        state_d = ACCUM;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      tap_q      <= 8'd0;
      acc_q      <= '0;
      stall_q    <= 1'b0;
      drop_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tap_q      <= tap_d;
      acc_q      <= acc_d;
      stall_q    <= (count >= CW'(FIFO_DEPTH - 1));
      if (push && full && !pop) begin
        drop_err_q <= 1'b1;
      end
    end
  end

  conv_out_fifo #(
    .WIDTH (OUTW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .count    (count),
    .head_dat (head)
  );

  assign pix_valid    = (count != '0);
  assign bus.pix_valid = pix_valid;
  // Gate the head so the pixel bus reads zero whenever nothing is queued.
  assign bus.pix_data = pix_valid ? head[OUTW-1:0] : '0;
  assign bus.pix_sat  = pix_valid ? head[OUTW] : 1'b0;
  assign bus.stall    = stall_q;
  assign bus.tap_cnt  = tap_q;
  assign bus.drop_err = drop_err_q;

endmodule

// File: tb/tb_conv_window_acc.sv
module tb_conv_window_acc;
  import conv_pkg::*;

  localparam int KTAPS = 9;
  localparam int SHIFT = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  conv_window_acc_if bus();

  conv_window_acc #(.KTAPS(KTAPS), .SHIFT(SHIFT), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    longint pix;
    bit     sat;
  } pix_t;

  int     checks = 0;
  int     errors = 0;
  pix_t   q[$];
  longint win[$];
  bit     m_drop = 1'b0;
  int     n_pop = 0;
  bit     rand_ready = 1'b0;

  task automatic chk(input string tag, input logic signed [63:0] obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain sum of the window's products, rounded and clamped.
  function automatic pix_t ref_pixel();
    longint s = 0;
    longint r;
    longint lim = longint'(1) <<< 15;
    pix_t   px;
    foreach (win[i]) s += win[i];
    r = (s + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
    px.sat = 1'b0;
    px.pix = r;
    if (r > lim - 1) begin px.pix = lim - 1; px.sat = 1'b1; end
    if (r < -lim)    begin px.pix = -lim;    px.sat = 1'b1; end
    return px;
  endfunction

  // One clock: drive inputs, check outputs against the model, advance model and DUT.
  task automatic step(input bit v, input logic signed [31:0] p, input bit fs);
    bit   do_pop;
    bit   have_px = 1'b0;
    bit   blocked = 1'b0;
    pix_t px;
    bus.prod_valid  = v;
    bus.prod_in     = p;
    bus.frame_start = fs;
    if (rand_ready) bus.pix_ready = 1'($urandom_range(0, 1));
    chk("pix_valid", bus.pix_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("pix_data", bus.pix_data, q[0].pix);
      chk("pix_sat", bus.pix_sat, q[0].sat);
    end
    chk("tap_cnt", bus.tap_cnt, win.size());
    do_pop = bus.pix_ready && (q.size() != 0);
    if (fs) begin
      win.delete();
      if (v) win.push_back(p);
    end else if (v) begin
      win.push_back(p);
      if (win.size() == KTAPS) begin
        px = ref_pixel();
        win.delete();
        have_px = 1'b1;
        if (q.size() == DEPTH && !do_pop) begin
          blocked = 1'b1;
          m_drop  = 1'b1;
        end
      end
    end
    if (do_pop) begin
      void'(q.pop_front());
      n_pop++;
    end
    if (have_px && !blocked) q.push_back(px);
    @(posedge clk);
    #1;
    chk("drop_err", bus.drop_err, m_drop);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
  endtask

  // First tap p0, remaining taps pr, with up to maxgap idle cycles before each tap.
  task automatic win_const(input logic signed [31:0] p0, input logic signed [31:0] pr, input int maxgap);
    for (int i = 0; i < KTAPS; i++) begin
      if (maxgap > 0) idle($urandom_range(0, maxgap));
      step(1'b1, (i == 0) ? p0 : pr, 1'b0);
    end
  endtask

  task automatic win_rand(input bit wide, input int maxgap);
    logic signed [31:0] p;
    for (int i = 0; i < KTAPS; i++) begin
      if (maxgap > 0) idle($urandom_range(0, maxgap));
      p = wide ? 32'($urandom) : 32'(int'($urandom_range(0, 40000)) - 20000);
      step(1'b1, p, 1'b0);
    end
  endtask

  task automatic expect_pix(input string tag, input longint pix, input bit sat);
    chk({tag, "_valid"}, bus.pix_valid, 1);
    chk({tag, "_data"}, bus.pix_data, pix);
    chk({tag, "_sat"}, bus.pix_sat, sat);
  endtask

  int n0;

  initial begin
    bus.prod_valid  = 1'b0;
    bus.prod_in     = '0;
    bus.frame_start = 1'b0;
    bus.pix_ready   = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pix_valid", bus.pix_valid, 0);
    chk("rst_pix_data", bus.pix_data, 0);
    chk("rst_pix_sat", bus.pix_sat, 0);
    chk("rst_stall", bus.stall, 0);
    chk("rst_tap_cnt", bus.tap_cnt, 0);
    chk("rst_drop_err", bus.drop_err, 0);
    reset = 1'b1;
    idle(2);

    // 1. Basic window: pixel visible one cycle after the 9th tap
    win_const(256, 256, 0);
    expect_pix("t1", 9, 0);
    idle(2);

    // 2. Rounding
    win_const(128, 0, 0);   expect_pix("t2a", 1, 0);  idle(1);
    win_const(-129, 0, 0);  expect_pix("t2b", -1, 0); idle(1);
    win_const(-128, 0, 0);  expect_pix("t2c", 0, 0);  idle(1);

    // 3. Saturation
    win_const(32'h7FFF_FFFF, 32'h7FFF_FFFF, 0); expect_pix("t3p", 32767, 1);  idle(1);
    win_const(32'h8000_0000, 32'h8000_0000, 0); expect_pix("t3n", -32768, 1); idle(1);

    // 4. Gaps inside a window, then frame_start aborts
    win_const(256, 256, 3);
    expect_pix("t4gap", 9, 0);
    idle(2);
    for (int i = 0; i < 4; i++) step(1'b1, 32'sd1000, 1'b0);
    step(1'b0, '0, 1'b1);
    chk("t4_fs_tap", bus.tap_cnt, 0);
    idle(2);
    chk("t4_fs_nopix", bus.pix_valid, 0);
    win_const(256, 256, 1);
    expect_pix("t4_after_fs", 9, 0);
    idle(2);
    // frame_start with a product on the would-be last tap: no pixel, that product is tap 0
    for (int i = 0; i < KTAPS - 1; i++) step(1'b1, 32'sd5000, 1'b0);
    step(1'b1, 32'sd512, 1'b1);
    chk("t4_fs_last_tap", bus.tap_cnt, 1);
    chk("t4_fs_last_nopix", bus.pix_valid, 0);
    for (int i = 0; i < KTAPS - 1; i++) step(1'b1, 32'sd256, 1'b0);
    expect_pix("t4_fs_last", 10, 0);
    idle(2);

    // Randomized windows with random gaps and random pix_ready
    rand_ready = 1'b1;
    for (int w = 0; w < 24; w++) win_rand(w[0], 2);
    rand_ready = 1'b0;
    bus.pix_ready = 1'b1;
    idle(4);

    // 5. Backpressure: 4 pixels fill the FIFO, the 5th is dropped
    chk("t5_empty", bus.pix_valid, 0);
    bus.pix_ready = 1'b0;
    win_rand(1'b0, 0);
    win_rand(1'b0, 0);
    idle(2);
    chk("t5_stall_lo", bus.stall, 0);
    win_rand(1'b0, 0);
    idle(2);
    chk("t5_stall_hi", bus.stall, 1);
    win_rand(1'b0, 0);
    idle(1);
    chk("t5_drop_lo", bus.drop_err, 0);
    win_rand(1'b0, 0);
    idle(1);
    chk("t5_drop_hi", bus.drop_err, 1);
    chk("t5_model_depth", q.size(), 4);
    n0 = n_pop;
    bus.pix_ready = 1'b1;
    idle(8);
    chk("t5_drained", n_pop - n0, 4);
    chk("t5_after_drain", bus.pix_valid, 0);
    chk("t5_stall_clr", bus.stall, 0);

    // 6. Reset mid-window with a queued pixel and drop_err set
    bus.pix_ready = 1'b0;
    win_rand(1'b0, 0);
    for (int i = 0; i < 5; i++) step(1'b1, 32'sd777, 1'b0);
    reset = 1'b0;
    q.delete();
    win.delete();
    m_drop = 1'b0;
    #2;
    chk("t6_pix_valid", bus.pix_valid, 0);
    chk("t6_pix_data", bus.pix_data, 0);
    chk("t6_pix_sat", bus.pix_sat, 0);
    chk("t6_stall", bus.stall, 0);
    chk("t6_tap_cnt", bus.tap_cnt, 0);
    chk("t6_drop_err", bus.drop_err, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.pix_ready = 1'b1;
    idle(1);
    win_const(256, 256, 0);
    expect_pix("t6_after", 9, 0);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
